// File: rtl/uart_tx_fifo_if.sv
// Byte-queue side of the UART transmitter: write strobe/ready, serial line and status.
// The producer drives data_i/data_v_i; the transmitter drives everything else.
interface uart_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] data_i;
  logic              data_v_i;
  logic              data_rdy_o;
  logic              tx_o;
  logic              busy_o;
  logic [LVL_W-1:0]  level_o;
  logic              overflow_o;

  modport master (
    output data_i, data_v_i,
    input  data_rdy_o, tx_o, busy_o, level_o, overflow_o
  );

  modport slave (
    input  data_i, data_v_i,
    output data_rdy_o, tx_o, busy_o, level_o, overflow_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO: first start bit one cycle after a write into an idle, empty queue.
// data_rdy_o drops while the FIFO is full; writes then are dropped and flagged on overflow_o.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  uart_tx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              ovf_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;

  logic              empty, full, push, pop, load, tick;
  logic [DATA_W-1:0] head;

  assign head  = mem[rd_ptr_q];
  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign push  = bus.data_v_i && !full;
  assign tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign pop   = load;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) load = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 4'(DATA_W - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = ST_PAR;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more data is waiting.
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              bit_d   = '0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d = ST_START;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // Full is judged on the registered level, so a same-cycle pop does not rescue the write.
      ovf_q <= bus.data_v_i && full;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= bus.data_i;
  end

  assign bus.data_rdy_o = !full;
  assign bus.tx_o       = tx_q;
  assign bus.busy_o     = (state_q != ST_IDLE) || !empty;
  assign bus.level_o    = level_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Five transmitter configurations share one clock; a receiver model per instance decodes
// tx_o and compares each frame against the scoreboard of accepted writes.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]       wv;
  logic [4:0][8:0]  wdat;
  logic [4:0]       txs, busys, rdys, ovfs;
  logic [4:0][7:0]  lvls;

  int n_checks = 0;
  int n_errors = 0;
  int rst_gen  = 0;

  typedef struct {
    int         idx;
    logic [8:0] data;
    bit         b2b;
  } sb_t;
  sb_t exp_q[$];

  logic [7:0] burst [6];

  uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(4))  if_a ();
  uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(16)) if_b ();
  uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(16)) if_c ();
  uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(4))  if_d ();
  uart_tx_fifo_if #(.DATA_W(7), .FIFO_DEPTH(4))  if_e ();

  uart_tx_fifo #(.CLK_DIV(4), .DATA_W(8), .FIFO_DEPTH(4),  .PARITY(0), .STOP_BITS(1))
    u_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_W(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1))
    u_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_W(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1))
    u_c (.clk_i(clk), .rst_i(rst), .bus(if_c));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_W(8), .FIFO_DEPTH(4),  .PARITY(0), .STOP_BITS(2))
    u_d (.clk_i(clk), .rst_i(rst), .bus(if_d));
  uart_tx_fifo #(.CLK_DIV(2), .DATA_W(7), .FIFO_DEPTH(4),  .PARITY(0), .STOP_BITS(1))
    u_e (.clk_i(clk), .rst_i(rst), .bus(if_e));

  assign if_a.data_v_i = wv[0];  assign if_a.data_i = wdat[0][7:0];
  assign if_b.data_v_i = wv[1];  assign if_b.data_i = wdat[1][7:0];
  assign if_c.data_v_i = wv[2];  assign if_c.data_i = wdat[2][7:0];
  assign if_d.data_v_i = wv[3];  assign if_d.data_i = wdat[3][7:0];
  assign if_e.data_v_i = wv[4];  assign if_e.data_i = wdat[4][6:0];

  assign txs   = {if_e.tx_o, if_d.tx_o, if_c.tx_o, if_b.tx_o, if_a.tx_o};
  assign busys = {if_e.busy_o, if_d.busy_o, if_c.busy_o, if_b.busy_o, if_a.busy_o};
  assign rdys  = {if_e.data_rdy_o, if_d.data_rdy_o, if_c.data_rdy_o, if_b.data_rdy_o, if_a.data_rdy_o};
  assign ovfs  = {if_e.overflow_o, if_d.overflow_o, if_c.overflow_o, if_b.overflow_o, if_a.overflow_o};
  assign lvls[0] = 8'(if_a.level_o);
  assign lvls[1] = 8'(if_b.level_o);
  assign lvls[2] = 8'(if_c.level_o);
  assign lvls[3] = 8'(if_d.level_o);
  assign lvls[4] = 8'(if_e.level_o);

  always @(posedge clk) if (rst) rst_gen <= rst_gen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input int idx, input logic [8:0] d, input bit b2b);
    sb_t e;
    e.idx  = idx;
    e.data = (idx == 4) ? (d & 9'h07F) : (d & 9'h0FF);
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  // n consecutive samples of one line; val is the first, stable says whether all agreed.
  task automatic samp(input int idx, input int n, output logic val, output bit stable);
    stable = 1'b1;
    val    = 1'bx;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) val = txs[idx];
      else if (txs[idx] !== val) stable = 1'b0;
    end
  endtask

  task automatic monitor(input int idx, input int div, input int dw, input int par, input int sb);
    logic       v, pbit;
    bit         st, ok, stop_ok, b2b;
    logic [8:0] bits, m;
    int         gen;
    sb_t        e;
    b2b = 1'b0;
    forever begin
      @(negedge clk);
      if (b2b) check("b2b_start", 32'(txs[idx]), 32'd0);
      while (txs[idx] !== 1'b0) @(negedge clk);
      b2b     = 1'b0;
      gen     = rst_gen;
      ok      = 1'b1;
      stop_ok = 1'b1;
      bits    = '0;
      pbit    = 1'b0;
      samp(idx, div - 1, v, st);
      ok = ok && st && (v === 1'b0);
      for (int i = 0; i < dw; i++) begin
        samp(idx, div, v, st);
        bits[i] = v;
        ok = ok && st;
      end
      if (par != 0) begin
        samp(idx, div, v, st);
        pbit = v;
        ok = ok && st;
      end
      for (int s = 0; s < sb; s++) begin
        samp(idx, div, v, st);
        stop_ok = stop_ok && st && (v === 1'b1);
      end
      if (rst_gen == gen) begin
        check("frame_shape", 32'(ok), 32'd1);
        check("stop_bits", 32'(stop_ok), 32'd1);
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_src", idx, e.idx);
          check("rx_data", 32'(bits), 32'(e.data));
          if (par != 0) begin
            m = e.data;
            check("parity", 32'(pbit), (par == 1) ? 32'(~^m) : 32'(^m));
          end
          b2b = (exp_q.size() > 0) && exp_q[0].b2b && (exp_q[0].idx == idx);
        end
      end
    end
  endtask

  task automatic frame_timing(input int idx, input logic [8:0] d, input int flen);
    wv[idx]   = 1'b1;
    wdat[idx] = d;
    sb_push(idx, d, 1'b0);
    @(negedge clk);
    wv[idx] = 1'b0;
    check("e0_level", 32'(lvls[idx]), 32'd1);
    check("e0_tx", 32'(txs[idx]), 32'd1);
    check("e0_busy", 32'(busys[idx]), 32'd1);
    @(negedge clk);
    check("e1_tx", 32'(txs[idx]), 32'd0);
    check("e1_level", 32'(lvls[idx]), 32'd0);
    repeat (flen - 1) @(negedge clk);
    check("busy_tail", 32'(busys[idx]), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busys[idx]), 32'd0);
    check("idle_tx", 32'(txs[idx]), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      monitor(0, 4, 8, 0, 1);
      monitor(1, 4, 8, 2, 1);
      monitor(2, 4, 8, 1, 1);
      monitor(3, 4, 8, 0, 2);
      monitor(4, 2, 7, 0, 1);
    join_none
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    burst = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hFF, 8'h3C};
    rst  = 1'b1;
    wv   = '0;
    wdat = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("rst_tx", 32'(txs[i]), 32'd1);
      check("rst_rdy", 32'(rdys[i]), 32'd1);
      check("rst_busy", 32'(busys[i]), 32'd0);
      check("rst_level", 32'(lvls[i]), 32'd0);
      check("rst_ovf", 32'(ovfs[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single 8N1 frame and its exact timing.
    frame_timing(0, 9'h069, 40);
    drain();

    // Even and odd parity, with four and three ones in the byte.
    frame_timing(1, 9'h069, 44);
    frame_timing(1, 9'h007, 44);
    frame_timing(2, 9'h069, 44);
    frame_timing(2, 9'h007, 44);
    drain();

    // Six back-to-back writes into a 4-deep FIFO; the sixth is dropped.
    wv[0]   = 1'b1;
    wdat[0] = 9'(burst[0]);
    sb_push(0, 9'(burst[0]), 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("burst_level", 32'(lvls[0]), (k == 1) ? 32'd1 : 32'(k - 1));
      check("burst_rdy", 32'(rdys[0]), (k == 5) ? 32'd0 : 32'd1);
      check("burst_ovf", 32'(ovfs[0]), 32'd0);
      wdat[0] = 9'(burst[k]);
      if (k <= 4) sb_push(0, 9'(burst[k]), 1'b1);
    end
    @(negedge clk);
    wv[0] = 1'b0;
    check("ovf_pulse", 32'(ovfs[0]), 32'd1);
    check("ovf_level", 32'(lvls[0]), 32'd4);
    @(negedge clk);
    check("ovf_clear", 32'(ovfs[0]), 32'd0);
    check("ovf_level_hold", 32'(lvls[0]), 32'd4);
    repeat (194) @(negedge clk);
    check("burst_busy_tail", 32'(busys[0]), 32'd1);
    @(negedge clk);
    check("burst_busy_fall", 32'(busys[0]), 32'd0);
    drain();

    // Two stop bits between consecutive frames.
    wv[3]   = 1'b1;
    wdat[3] = 9'h0A5;
    sb_push(3, 9'h0A5, 1'b0);
    @(negedge clk);
    wdat[3] = 9'h03C;
    sb_push(3, 9'h03C, 1'b1);
    @(negedge clk);
    wv[3] = 1'b0;
    drain();

    // Reset in the middle of a data bit with more bytes queued.
    wv[0]   = 1'b1;
    wdat[0] = 9'h011;
    sb_push(0, 9'h011, 1'b0);
    @(negedge clk);
    wdat[0] = 9'h022;
    sb_push(0, 9'h022, 1'b1);
    @(negedge clk);
    wdat[0] = 9'h033;
    sb_push(0, 9'h033, 1'b1);
    @(negedge clk);
    wv[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busys[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_tx", 32'(txs[0]), 32'd1);
    check("mid_rst_level", 32'(lvls[0]), 32'd0);
    check("mid_rst_busy", 32'(busys[0]), 32'd0);
    check("mid_rst_rdy", 32'(rdys[0]), 32'd1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txs[0] !== 1'b1 || busys[0] !== 1'b0) lows++;
    end
    check("quiet_after_rst", lows, 0);
    frame_timing(0, 9'h0C3, 40);
    drain();

    // 7-bit frames at two clocks per bit.
    for (int k = 0; k < 4; k++) begin
      frame_timing(4, (k % 2 == 0) ? 9'h0FF : 9'h000, 18);
      repeat (3) @(negedge clk);
    end
    frame_timing(4, 9'h0AA, 18);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
